mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the RV64I core's instruction-fetch port and data (load/store) port onto a single shared memory bus with a req/ack handshake. It drives the data-side ready that the pipeline Controller consumes as `data_ready`, so `waiting` deasserts exactly when a load/store completes. Grants are round-robin on contention. A per-transaction watchdog terminates a hung bus access with an error.

## Interface
- `ADDR_W`, 64: address width, both ports and bus.
- `DATA_W`, 64: data width; `STRB_W = DATA_W/8`.
- `MAX_WAIT`, 255: bus cycles without `m_ack` before a timeout; must be ≥1.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `i_req` in 1: fetch request, held high until `i_ready`.
- `i_addr` in ADDR_W: fetch address.
- `i_rdata` out DATA_W: fetch data, valid while `i_ready`.
- `i_ready` out 1: one-cycle completion pulse.
- `d_req` in 1: load/store request, held until `d_ready`.
- `d_we` in 1: 1 = store.
- `d_strb` in STRB_W: byte enables, same encoding as `M_dm_w_en`.
- `d_addr` in ADDR_W, `d_wdata` in DATA_W: data address and store data.
- `d_rdata` out DATA_W: load data, valid while `d_ready`.
- `d_ready` out 1: one-cycle completion pulse; drives Controller `data_ready`.
- `m_req` out 1: bus request, held until ack.
- `m_we` out 1, `m_strb` out STRB_W, `m_addr` out ADDR_W, `m_wdata` out DATA_W: latched command.
- `m_rdata` in DATA_W: bus read data, valid with `m_ack`.
- `m_ack` in 1: bus completion, single cycle.
- `bus_err` out 1: pulses with ready when a transaction timed out.

## Operation
- FSM states: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- **IDLE**: samples requests.
  - Only one request high: grant that port.
  - Both high: grant the port not granted last. `last_grant` resets to I, so D wins the first tie.
  - On grant: latch command into `m_*` registers; next state is BUSY_x.
  - Fetch commands: `m_we=0`, `m_strb` all ones.
- **BUSY_x**: `m_req=1`, command stable. The wait counter increments each cycle.
  - `m_ack`: latch `m_rdata`; for stores, latch 0 instead. Next state RESP_x; `m_req` drops.
  - Counter reaches `MAX_WAIT` with no ack: latch rdata 0, set error flag, next state RESP_x.
  - Ack and timeout in the same cycle: ack wins, no error.
- **RESP_x**: `x_ready=1` for exactly one cycle; `bus_err` = error flag. Next state is always IDLE, which clears the flag and counter.
  - Requests are ignored in RESP. This prevents re-issuing the stale request that is still high while the pipeline advances.
- Requester drops `req` mid-BUSY: the transaction still completes and ready still pulses; the requester ignores it.
- `d_we=1` with `d_strb=0`: issued unchanged.
- `i_rdata`/`d_rdata` hold their last latched value outside the ready cycle.
- Counter width: `$clog2(MAX_WAIT+1)`. The counter saturates and never wraps.

## Timing
- All outputs are registered.
- Reset values: state IDLE, all `m_*`=0, `i_ready`=`d_ready`=0, rdata=0, `bus_err`=0, `last_grant`=I, counter 0.
- Reset mid-transaction: `m_req` drops asynchronously and the in-flight access is abandoned. No ready is issued.
- Request-to-ready, uncontended:
  - Cycle 0: `req` seen in IDLE.
  - Cycle 1: `m_req`=1.
  - Ack in cycle k≥1 gives ready in cycle k+1, then IDLE in k+2.
  - Minimum latency 2 cycles; the next request is sampled 3 cycles after the previous one.
- Timeout: ready at cycle `MAX_WAIT+1` after `m_req` first rises.
- Contention: the losing port waits the full winner transaction plus its RESP cycle.

## Structure
- Shared package holds:
  - FSM state enum.
  - Grant encoding (`GNT_I`=0, `GNT_D`=1).
  - Existing byte-strobe constants (`Byte`, `Halfword`, `Word`, `Doubleword`), reused rather than redefined.
- One sub-module, `mem_wait_timer`: clear/enable inputs, `MAX_WAIT` parameter, `expired` output.
- Grant logic and FSM stay in `mem_arbiter`.

## Test plan
- Single load: `d_req=1`, `d_we=0`, `d_addr=0x1000`; bus acks in 2nd BUSY cycle with `m_rdata=0xDEADBEEF_CAFEF00D` -> `d_ready` pulses in cycle 3 with that data; `bus_err=0`.
- Store: `d_we=1`, `d_strb=8'h0F`, `d_wdata=0x11223344` -> `m_we=1`, `m_strb=0x0F`, `m_wdata` matches; after ack `d_ready`=1 with `d_rdata=0`.
- Contention: `i_req` and `d_req` high together from reset for 4 transactions, ack latency 1 -> bus grant order D, I, D, I; each ready pulses once.
- Timeout: `MAX_WAIT=4`, `m_ack` never asserted -> `m_req` high 4 cycles, then `d_ready=1`, `bus_err=1`, `d_rdata=0`, then IDLE.
- Ack on expiry cycle: `MAX_WAIT=4`, ack in 4th BUSY cycle -> ready with `m_rdata`, `bus_err=0`.
- Reset mid-BUSY: `rst` pulsed while `m_req=1` -> `m_req`=0 immediately, no ready, first post-reset tie granted to D.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arbiter_pkg;

    // Arbiter FSM states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } arb_state_e;

    // Which port owns (or last owned) the shared bus.
    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } grant_e;

    // Byte-strobe encodings shared with the core's data-memory write enables.
    localparam logic [7:0] Byte       = 8'h01;
    localparam logic [7:0] Halfword   = 8'h03;
    localparam logic [7:0] Word       = 8'h0F;
    localparam logic [7:0] Doubleword = 8'hFF;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundles the fetch port, data port and shared memory bus of the arbiter.
// Handshake: a requester raises x_req with a stable command and holds it
// until the one-cycle x_ready pulse; the arbiter holds m_req with a stable
// command until the bus returns a one-cycle m_ack.
// The master modport is the arbiter's view (it masters the memory bus and
// serves the two core ports); the slave modport is the surrounding core and
// memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    localparam int STRB_W = DATA_W / 8;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ready;

    logic              d_req;
    logic              d_we;
    logic [STRB_W-1:0] d_strb;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ready;

    logic              m_req;
    logic              m_we;
    logic [STRB_W-1:0] m_strb;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;
    logic              m_ack;
    logic              bus_err;

    modport master (
        input  i_req, i_addr,
        input  d_req, d_we, d_strb, d_addr, d_wdata,
        input  m_rdata, m_ack,
        output i_rdata, i_ready,
        output d_rdata, d_ready,
        output m_req, m_we, m_strb, m_addr, m_wdata,
        output bus_err
    );

    modport slave (
        output i_req, i_addr,
        output d_req, d_we, d_strb, d_addr, d_wdata,
        output m_rdata, m_ack,
        input  i_rdata, i_ready,
        input  d_rdata, d_ready,
        input  m_req, m_we, m_strb, m_addr, m_wdata,
        input  bus_err
    );
endinterface

// File: rtl/mem_wait_timer.sv
// Per-transaction watchdog: counts bus-wait cycles and flags when the next
// counted cycle reaches MAX_WAIT. The counter saturates and never wraps.
module mem_wait_timer #(
    parameter int MAX_WAIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_WAIT);
    localparam logic [CW-1:0] LAST  = CW'(MAX_WAIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Clear wins over counting; hold once the limit is reached.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Cycle number cnt_q+1 of the wait is the MAX_WAIT-th one.
    assign expired_o = (cnt_q >= LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter of the fetch and load/store ports onto one req/ack
// memory bus, with a watchdog that terminates hung accesses with bus_err.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int MAX_WAIT = 255
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus,
    output arb_state_e    state_o
);
    localparam int STRB_W = DATA_W / 8;

    arb_state_e        state_q, state_d;
    grant_e            last_grant_q, last_grant_d;
    logic              m_req_q, m_req_d;
    logic              m_we_q, m_we_d;
    logic [STRB_W-1:0] m_strb_q, m_strb_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              i_ready_q, i_ready_d;
    logic              d_ready_q, d_ready_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] resp_data;
    logic              timer_en, timer_clr, timer_expired;

    // The watchdog runs only while the bus is owned; any other state clears it.
    assign timer_en  = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign timer_clr = !timer_en;

    mem_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (timer_clr),
        .en_i      (timer_en),
        .expired_o (timer_expired)
    );

    // Next-state, grant and registered-output values.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        m_req_d      = m_req_q;
        m_we_d       = m_we_q;
        m_strb_d     = m_strb_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_ready_d    = 1'b0;
        d_ready_d    = 1'b0;
        err_d        = err_q;
        resp_data    = '0;
        case (state_q)
            IDLE: begin
                err_d = 1'b0;
                // D wins a tie unless it was granted last.
                if (bus.d_req && (!bus.i_req || (last_grant_q == GNT_I))) begin
                    state_d      = BUSY_D;
                    last_grant_d = GNT_D;
                    m_req_d      = 1'b1;
                    m_we_d       = bus.d_we;
                    m_strb_d     = bus.d_strb;
                    m_addr_d     = bus.d_addr;
                    m_wdata_d    = bus.d_wdata;
                end else if (bus.i_req) begin
                    state_d      = BUSY_I;
                    last_grant_d = GNT_I;
                    m_req_d      = 1'b1;
                    m_we_d       = 1'b0;
                    m_strb_d     = '1;
                    m_addr_d     = bus.i_addr;
                    m_wdata_d    = '0;
                end
            end
            BUSY_I, BUSY_D: begin
                // An ack in the expiry cycle still counts as a good completion.
                if (bus.m_ack || timer_expired) begin
                    m_req_d   = 1'b0;
                    err_d     = !bus.m_ack;
                    resp_data = (bus.m_ack && !m_we_q) ? bus.m_rdata : '0;
                    if (state_q == BUSY_I) begin
                        state_d   = RESP_I;
                        i_ready_d = 1'b1;
                        i_rdata_d = resp_data;
                    end else begin
                        state_d   = RESP_D;
                        d_ready_d = 1'b1;
                        d_rdata_d = resp_data;
                    end
                end
            end
            RESP_I, RESP_D: begin
                // Requests still high here are stale; never re-issue them.
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and round-robin history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_I;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Registered bus command, responses and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_req_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_strb_q  <= '0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_ready_q <= 1'b0;
            d_ready_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            m_req_q   <= m_req_d;
            m_we_q    <= m_we_d;
            m_strb_q  <= m_strb_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
            i_ready_q <= i_ready_d;
            d_ready_q <= d_ready_d;
            err_q     <= err_d;
        end
    end

    assign bus.m_req   = m_req_q;
    assign bus.m_we    = m_we_q;
    assign bus.m_strb  = m_strb_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.i_ready = i_ready_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.d_ready = d_ready_q;
    assign bus.bus_err = err_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected completions are queued when a
// request is raised and compared when the matching ready pulse appears.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    arb_state_e state;

    int n_assert = 0;
    int n_fail   = 0;
    int busy, lat;

    // Entry: {d_ready, i_ready, bus_err, rdata of the completing port}
    logic [66:0] exp_q[$];

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) bus ();

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_WAIT(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Plays the memory: acks in BUSY cycle ack_at (0 = never), checks the
    // issued command, then scores the ready pulse and the following IDLE cycle.
    task automatic serve(input string tag, input int ack_at, input logic [63:0] rdata,
                         input logic e_we, input logic [7:0] e_strb,
                         input logic [63:0] e_addr, input logic [63:0] e_wdata,
                         input logic [1:0] drop, output int n_busy, output int n_lat);
        logic [66:0] obs;
        logic [66:0] exp;
        bit done;
        bit timed_out;
        done = 0;
        timed_out = 0;
        n_busy = 0;
        n_lat = 0;
        while (!done) begin
            @(negedge clk);
            n_lat++;
            bus.m_ack = 1'b0;
            if (bus.i_ready || bus.d_ready) begin
                done = 1;
            end else if (n_lat > 40) begin
                n_assert++;
                n_fail++;
                $display("FAIL %s_ready_timeout: no ready within 40 cycles", tag);
                done = 1;
                timed_out = 1;
            end else if (bus.m_req) begin
                n_busy++;
                if (n_busy == 1) begin
                    chk({tag, "_m_we"}, bus.m_we, e_we);
                    chk({tag, "_m_strb"}, bus.m_strb, e_strb);
                    chk({tag, "_m_addr"}, bus.m_addr, e_addr);
                    if (e_we) chk({tag, "_m_wdata"}, bus.m_wdata, e_wdata);
                end
                if (n_busy == ack_at) begin
                    bus.m_ack   = 1'b1;
                    bus.m_rdata = rdata;
                end
            end
        end
        if (!timed_out) begin
            chk({tag, "_m_req_dropped"}, bus.m_req, 1'b0);
            obs = {bus.d_ready, bus.i_ready, bus.bus_err,
                   bus.d_ready ? bus.d_rdata : bus.i_rdata};
            if (exp_q.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL %s_unexpected_ready: observed 0x%0h with empty queue", tag, obs);
            end else begin
                exp = exp_q.pop_front();
                chk({tag, "_result"}, obs, exp);
            end
            if (drop[1]) bus.d_req = 1'b0;
            if (drop[0]) bus.i_req = 1'b0;
            @(negedge clk);
            chk({tag, "_idle_after"}, {bus.i_ready, bus.d_ready, bus.bus_err, state},
                {3'b000, IDLE});
        end
    endtask

    initial begin
        rst         = 1'b1;
        bus.i_req   = 1'b0;
        bus.i_addr  = '0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_strb  = '0;
        bus.d_addr  = '0;
        bus.d_wdata = '0;
        bus.m_rdata = '0;
        bus.m_ack   = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_m_req", bus.m_req, 1'b0);
        chk("rst_ready", {bus.i_ready, bus.d_ready, bus.bus_err}, 3'b000);
        chk("rst_m_cmd", {bus.m_we, bus.m_strb, bus.m_addr, bus.m_wdata}, '0);
        chk("rst_rdata", {bus.i_rdata, bus.d_rdata}, '0);
        chk("rst_state", state, IDLE);
        rst = 1'b0;
        @(negedge clk);

        // Single load, ack in 2nd BUSY cycle
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_strb = Doubleword;
        bus.d_addr = 64'h1000; bus.d_wdata = '0;
        exp_q.push_back({1'b1, 1'b0, 1'b0, 64'hDEADBEEF_CAFEF00D});
        serve("load", 2, 64'hDEADBEEF_CAFEF00D, 1'b0, 8'hFF, 64'h1000, 64'h0, 2'b10, busy, lat);
        chk("load_latency", lat, 3);
        chk("load_rdata_hold", bus.d_rdata, 64'hDEADBEEF_CAFEF00D);

        // Store: bus data ignored, d_rdata reads 0; minimum latency
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_strb = Word;
        bus.d_addr = 64'h2000; bus.d_wdata = 64'h11223344;
        exp_q.push_back({1'b1, 1'b0, 1'b0, 64'h0});
        serve("store", 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 8'h0F, 64'h2000, 64'h11223344,
              2'b10, busy, lat);
        chk("store_latency", lat, 2);

        // Uncontended fetch
        bus.i_req = 1'b1; bus.i_addr = 64'h80;
        exp_q.push_back({1'b0, 1'b1, 1'b0, 64'h0000_0013_0000_0093});
        serve("fetch", 1, 64'h0000_0013_0000_0093, 1'b0, 8'hFF, 64'h80, 64'h0, 2'b01, busy, lat);
        chk("fetch_d_rdata_hold", bus.d_rdata, 64'h0);

        // Timeout: no ack ever
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_strb = Doubleword; bus.d_addr = 64'h4000;
        bus.m_rdata = 64'h1234_5678_9ABC_DEF0;
        exp_q.push_back({1'b1, 1'b0, 1'b1, 64'h0});
        serve("timeout", 0, 64'h0, 1'b0, 8'hFF, 64'h4000, 64'h0, 2'b10, busy, lat);
        chk("timeout_busy_cycles", busy, 4);
        chk("timeout_latency", lat, 5);

        // Ack in the expiry cycle wins
        bus.d_req = 1'b1; bus.d_addr = 64'h5000;
        exp_q.push_back({1'b1, 1'b0, 1'b0, 64'h5555_AAAA_0123_4567});
        serve("ack_at_expiry", 4, 64'h5555_AAAA_0123_4567, 1'b0, 8'hFF, 64'h5000, 64'h0,
              2'b10, busy, lat);
        chk("ack_at_expiry_busy", busy, 4);

        // Store with no byte enables passes through unchanged
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_strb = 8'h00;
        bus.d_addr = 64'h6000; bus.d_wdata = 64'hABCD;
        exp_q.push_back({1'b1, 1'b0, 1'b0, 64'h0});
        serve("store_strb0", 3, 64'h77, 1'b1, 8'h00, 64'h6000, 64'hABCD, 2'b10, busy, lat);

        // Contention from reset: D, I, D, I
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 64'h100;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_strb = Doubleword; bus.d_addr = 64'h3000;
        exp_q.push_back({1'b1, 1'b0, 1'b0, 64'hD0});
        exp_q.push_back({1'b0, 1'b1, 1'b0, 64'h10});
        exp_q.push_back({1'b1, 1'b0, 1'b0, 64'hD1});
        exp_q.push_back({1'b0, 1'b1, 1'b0, 64'h11});
        serve("rr0_d", 1, 64'hD0, 1'b0, 8'hFF, 64'h3000, 64'h0, 2'b00, busy, lat);
        serve("rr1_i", 1, 64'h10, 1'b0, 8'hFF, 64'h100, 64'h0, 2'b00, busy, lat);
        serve("rr2_d", 1, 64'hD1, 1'b0, 8'hFF, 64'h3000, 64'h0, 2'b00, busy, lat);
        serve("rr3_i", 1, 64'h11, 1'b0, 8'hFF, 64'h100, 64'h0, 2'b11, busy, lat);

        // Reset mid-BUSY after a D grant: abort, then D still wins the tie
        bus.d_req = 1'b1; bus.d_addr = 64'h7000;
        @(negedge clk);
        chk("midrst_m_req_before", bus.m_req, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_m_req_async", bus.m_req, 1'b0);
        chk("midrst_state", state, IDLE);
        @(negedge clk);
        chk("midrst_no_ready", {bus.i_ready, bus.d_ready, bus.bus_err}, 3'b000);
        rst = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 64'h200;
        exp_q.push_back({1'b1, 1'b0, 1'b0, 64'h77});
        exp_q.push_back({1'b0, 1'b1, 1'b0, 64'h22});
        serve("postrst_d", 1, 64'h77, 1'b0, 8'hFF, 64'h7000, 64'h0, 2'b10, busy, lat);
        serve("postrst_i", 2, 64'h22, 1'b0, 8'hFF, 64'h200, 64'h0, 2'b01, busy, lat);

        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
